// File: rtl/nlms_pkg.sv
// Shared types for the NLMS run-time sequencer: FSM states, operation codes
// and the adaptive-mode decode (reserved code behaves as filter-only).
package nlms_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_LOAD,
        S_PUSH,
        S_FILTER,
        S_DRAIN,
        S_RESULT,
        S_UPDATE,
        S_UPD_DRAIN,
        S_WRITE
    } nlms_seq_state_t;

    typedef enum logic [1:0] {
        OP_FILTER = 2'd0,
        OP_LMS    = 2'd1,
        OP_NLMS   = 2'd2,
        OP_RSVD   = 2'd3
    } nlms_op_t;

    function automatic logic op_is_adaptive(input nlms_op_t op);
        return (op == OP_LMS) || (op == OP_NLMS);
    endfunction

endpackage

// File: rtl/nlms_sequencer_delay.sv
// Fixed-depth shift register delaying a control word by DEPTH cycles.
// Shifts only while en is high, so a stalled pipeline keeps its contents.
module nlms_delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] pipe [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) pipe[i] <= '0;
        end else if (en) begin
            pipe[0] <= din;
            for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign dout = pipe[DEPTH-1];

endmodule

// File: rtl/nlms_sequencer.sv
// Per-sample sequencer driving every buffer/MAC strobe of the NLMS core.
// Filter-only B+L+5 cycles/sample, adaptive 2B+2L+6; en low freezes all state and zeroes strobes.
module nlms_sequencer
    import nlms_pkg::*;
#(
    parameter int LOG2_H_BUFF_HEIGHT   = 4,
    parameter int LOG2_X_D_BUFF_HEIGHT = 10,
    parameter int SAMPLE_WIDTH         = 16,
    parameter int MAC_LATENCY          = 3
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            en,
    input  logic                            start,
    input  logic [1:0]                      operation,
    input  logic                            y_as_out,
    input  logic [SAMPLE_WIDTH-1:0]         x_samples_count,
    input  logic [SAMPLE_WIDTH-1:0]         h_coef_blocks_count,
    output logic                            finished,
    output logic                            x_buff_re,
    output logic [LOG2_X_D_BUFF_HEIGHT-1:0] x_buff_raddr,
    output logic                            d_buff_re,
    output logic [LOG2_X_D_BUFF_HEIGHT-1:0] d_buff_raddr,
    output logic                            x_fifo_push,
    output logic                            h_buff_re,
    output logic [LOG2_H_BUFF_HEIGHT-1:0]   h_buff_raddr,
    output logic                            h_buff_we,
    output logic [LOG2_H_BUFF_HEIGHT-1:0]   h_buff_waddr,
    output logic                            dp_acc_clr,
    output logic                            dp_acc_en,
    output logic                            dp_capture_y,
    output logic                            dp_calc_err,
    output logic                            dp_upd_en,
    output logic                            out_buff_we,
    output logic [LOG2_X_D_BUFF_HEIGHT-1:0] out_buff_waddr,
    output logic                            dp_out_sel
);

    localparam int AW = LOG2_X_D_BUFF_HEIGHT;
    localparam int AH = LOG2_H_BUFF_HEIGHT;
    localparam int NW = AW + 1;
    localparam int BW = AH + 1;
    localparam int DW = $clog2(MAC_LATENCY + 2);
    localparam logic [31:0]   X_DEPTH    = 32'(1) << AW;
    localparam logic [31:0]   H_DEPTH    = 32'(1) << AH;
    localparam logic [DW-1:0] DRAIN_LAST = DW'(MAC_LATENCY);

    nlms_seq_state_t state, state_nxt;
    logic [NW-1:0]   n, n_cnt;
    logic [BW-1:0]   b, b_cnt;
    logic [DW-1:0]   d;
    nlms_op_t        op_q;
    logic            y_sel_q;
    logic            fin_q;

    logic [NW-1:0] n_clip;
    logic [BW-1:0] b_clip;
    logic          run_empty, b_last, d_last, n_last;

    // Clip counts to buffer depth; counters are one bit wider so full depth never wraps.
    always_comb begin
        n_clip = (32'(x_samples_count) > X_DEPTH) ? NW'(X_DEPTH) : NW'(x_samples_count);
        b_clip = (32'(h_coef_blocks_count) > H_DEPTH) ? BW'(H_DEPTH) : BW'(h_coef_blocks_count);
    end

    assign run_empty = (x_samples_count == '0) || (h_coef_blocks_count == '0);
    assign b_last    = (b == b_cnt - 1'b1);
    assign d_last    = (d == DRAIN_LAST);
    assign n_last    = (n == n_cnt - 1'b1);

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else if (en) state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:      if (start && !run_empty) state_nxt = S_LOAD;
            S_LOAD:      state_nxt = S_PUSH;
            S_PUSH:      state_nxt = S_FILTER;
            S_FILTER:    if (b_last) state_nxt = S_DRAIN;
            S_DRAIN:     if (d_last) state_nxt = S_RESULT;
            S_RESULT:    state_nxt = op_is_adaptive(op_q) ? S_UPDATE : S_WRITE;
            S_UPDATE:    if (b_last) state_nxt = S_UPD_DRAIN;
            S_UPD_DRAIN: if (d_last) state_nxt = S_WRITE;
            S_WRITE:     state_nxt = n_last ? S_IDLE : S_LOAD;
            default:     state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            n       <= '0;
            b       <= '0;
            d       <= '0;
            n_cnt   <= '0;
            b_cnt   <= '0;
            op_q    <= OP_FILTER;
            y_sel_q <= 1'b0;
            fin_q   <= 1'b0;
        end else if (en) begin
            if (state == S_IDLE && start) begin
                op_q    <= nlms_op_t'(operation);
                y_sel_q <= y_as_out;
                n_cnt   <= n_clip;
                b_cnt   <= b_clip;
                n       <= '0;
                fin_q   <= run_empty;
            end
            if (state == S_WRITE) begin
                if (n_last) fin_q <= 1'b1;
                else        n     <= n + 1'b1;
            end
            b <= ((state == S_FILTER || state == S_UPDATE) && !b_last) ? b + 1'b1 : '0;
            d <= ((state == S_DRAIN || state == S_UPD_DRAIN) && !d_last) ? d + 1'b1 : '0;
        end
    end

    logic ld_r, push_r, hre_f_r, hre_u_r, clr_r, cap_r, owe_r;

    always_comb begin
        ld_r    = 1'b0;
        push_r  = 1'b0;
        hre_f_r = 1'b0;
        hre_u_r = 1'b0;
        clr_r   = 1'b0;
        cap_r   = 1'b0;
        owe_r   = 1'b0;
        case (state)
            S_LOAD:   ld_r = 1'b1;
            S_PUSH:   push_r = 1'b1;
            S_FILTER: begin
                hre_f_r = 1'b1;
                clr_r   = (b == '0);
            end
            S_RESULT: cap_r = 1'b1;
            S_UPDATE: hre_u_r = 1'b1;
            S_WRITE:  owe_r = 1'b1;
            default:  ;
        endcase
    end

    logic          acc_d, upd_d, wb_we;
    logic [AH-1:0] wb_addr;

    nlms_delay_line #(.WIDTH(1), .DEPTH(1)) u_acc_dly (
        .clk(clk), .rst(rst), .en(en), .din(hre_f_r), .dout(acc_d)
    );

    nlms_delay_line #(.WIDTH(1), .DEPTH(1)) u_upd_dly (
        .clk(clk), .rst(rst), .en(en), .din(hre_u_r), .dout(upd_d)
    );

    // Write-back lags the coefficient read by the full MAC pipeline plus the read latency.
    nlms_delay_line #(.WIDTH(AH + 1), .DEPTH(MAC_LATENCY + 1)) u_wb_dly (
        .clk(clk), .rst(rst), .en(en), .din({hre_u_r, b[AH-1:0]}), .dout({wb_we, wb_addr})
    );

    assign finished       = fin_q;
    assign x_buff_re      = en & ld_r;
    assign d_buff_re      = en & ld_r;
    assign x_buff_raddr   = n[AW-1:0];
    assign d_buff_raddr   = n[AW-1:0];
    assign x_fifo_push    = en & push_r;
    assign h_buff_re      = en & (hre_f_r | hre_u_r);
    assign h_buff_raddr   = b[AH-1:0];
    assign h_buff_we      = en & wb_we;
    assign h_buff_waddr   = wb_addr;
    assign dp_acc_clr     = en & clr_r;
    assign dp_acc_en      = en & acc_d;
    assign dp_capture_y   = en & cap_r;
    assign dp_calc_err    = en & cap_r;
    assign dp_upd_en      = en & upd_d;
    assign out_buff_we    = en & owe_r;
    assign out_buff_waddr = n[AW-1:0];
    assign dp_out_sel     = en & owe_r & y_sel_q;

endmodule

// File: tb/tb_nlms_sequencer.sv
// Directed bench for nlms_sequencer: instance 0 has MAC latency 3, instance 1 latency 2,
// both share inputs; cycle numbers count from the edge that samples start (cycle 1 = LOAD).
module tb_nlms_sequencer;
    import nlms_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, en, start, y_as_out;
    logic [1:0]  operation;
    logic [15:0] x_samples_count, h_coef_blocks_count;

    logic       fin[2], xre[2], dre[2], push[2], hre[2], hwe[2], clr[2];
    logic       acc[2], cap[2], err[2], upd[2], owe[2], osel[2];
    logic [9:0] xra[2], dra[2], owa[2];
    logic [3:0] hra[2], hwa[2];

    nlms_sequencer #(.MAC_LATENCY(3)) dut0 (
        .clk(clk), .rst(rst), .en(en), .start(start), .operation(operation), .y_as_out(y_as_out),
        .x_samples_count(x_samples_count), .h_coef_blocks_count(h_coef_blocks_count),
        .finished(fin[0]), .x_buff_re(xre[0]), .x_buff_raddr(xra[0]),
        .d_buff_re(dre[0]), .d_buff_raddr(dra[0]), .x_fifo_push(push[0]),
        .h_buff_re(hre[0]), .h_buff_raddr(hra[0]), .h_buff_we(hwe[0]), .h_buff_waddr(hwa[0]),
        .dp_acc_clr(clr[0]), .dp_acc_en(acc[0]), .dp_capture_y(cap[0]), .dp_calc_err(err[0]),
        .dp_upd_en(upd[0]), .out_buff_we(owe[0]), .out_buff_waddr(owa[0]), .dp_out_sel(osel[0])
    );

    nlms_sequencer #(.MAC_LATENCY(2)) dut1 (
        .clk(clk), .rst(rst), .en(en), .start(start), .operation(operation), .y_as_out(y_as_out),
        .x_samples_count(x_samples_count), .h_coef_blocks_count(h_coef_blocks_count),
        .finished(fin[1]), .x_buff_re(xre[1]), .x_buff_raddr(xra[1]),
        .d_buff_re(dre[1]), .d_buff_raddr(dra[1]), .x_fifo_push(push[1]),
        .h_buff_re(hre[1]), .h_buff_raddr(hra[1]), .h_buff_we(hwe[1]), .h_buff_waddr(hwa[1]),
        .dp_acc_clr(clr[1]), .dp_acc_en(acc[1]), .dp_capture_y(cap[1]), .dp_calc_err(err[1]),
        .dp_upd_en(upd[1]), .out_buff_we(owe[1]), .out_buff_waddr(owa[1]), .dp_out_sel(osel[1])
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [63:0] t_hre, t_hwe, t_owe, t_osel, t_fin, t_xre, t_clr, t_acc, t_upd, t_cap, t_any;
    int          t_hra[64], t_hwa[64], t_owa[64];

    function automatic int first_hi(input logic [63:0] v);
        for (int i = 0; i < 64; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic logic [63:0] bits2(input int a, input int c);
        logic [63:0] m;
        m = '0;
        if (a >= 0) m[a] = 1'b1;
        if (c >= 0) m[c] = 1'b1;
        return m;
    endfunction

    task automatic pulse_start(input logic [1:0] op, input logic ysel, input int nn, input int bb);
        @(negedge clk);
        operation           = op;
        y_as_out            = ysel;
        x_samples_count     = 16'(nn);
        h_coef_blocks_count = 16'(bb);
        start               = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Records one instance's outputs for cycles 1..ncyc; en is dropped over [stall_at, stall_at+stall_len).
    task automatic trace(input int inst, input int ncyc, input int stall_at, input int stall_len,
                         input int start_at);
        t_hre = '0; t_hwe = '0; t_owe = '0; t_osel = '0; t_fin = '0; t_xre = '0;
        t_clr = '0; t_acc = '0; t_upd = '0; t_cap = '0; t_any = '0;
        for (int c = 1; c <= ncyc; c++) begin
            en    = !(c >= stall_at && c < stall_at + stall_len);
            start = (c == start_at);
            @(negedge clk);
            t_hre[c] = hre[inst];  t_hra[c] = int'(hra[inst]);
            t_hwe[c] = hwe[inst];  t_hwa[c] = int'(hwa[inst]);
            t_owe[c] = owe[inst];  t_owa[c] = int'(owa[inst]);
            t_osel[c] = osel[inst];
            t_fin[c] = fin[inst];  t_xre[c] = xre[inst];
            t_clr[c] = clr[inst];  t_acc[c] = acc[inst];
            t_upd[c] = upd[inst];  t_cap[c] = cap[inst];
            t_any[c] = xre[inst] | dre[inst] | push[inst] | hre[inst] | hwe[inst] | clr[inst] |
                       acc[inst] | cap[inst] | err[inst] | upd[inst] | owe[inst] | osel[inst];
            @(posedge clk);
            #1;
        end
        en    = 1'b1;
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; start = 1'b0; operation = 2'd0; y_as_out = 1'b0;
        x_samples_count = '0; h_coef_blocks_count = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (fin[i] !== 1'b0) begin
                n_fail++; $display("FAIL reset_finished inst%0d got %b want 0", i, fin[i]);
            end
            n_checks++;
            if ({xre[i], dre[i], push[i], hre[i], hwe[i], clr[i], acc[i], cap[i], err[i],
                 upd[i], owe[i], osel[i]} !== 12'h0) begin
                n_fail++; $display("FAIL reset_strobes inst%0d some strobe high, want all 0", i);
            end
        end
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_mid_reset();
        pulse_start(2'd0, 1'b0, 2, 4);
        trace(0, 4, 0, 0, 0);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        trace(0, 10, 0, 0, 0);
        n_checks++;
        if (t_any !== 64'h0) begin
            n_fail++; $display("FAIL midreset_strobes got %h want 0", t_any);
        end
        n_checks++;
        if (t_fin !== 64'h0) begin
            n_fail++; $display("FAIL midreset_finished got %h want 0", t_fin);
        end
        pulse_start(2'd0, 1'b0, 1, 1);
        trace(0, 15, 0, 0, 0);
        n_checks++;
        if (t_owe !== bits2(9, -1)) begin
            n_fail++; $display("FAIL midreset_write got %h want %h", t_owe, bits2(9, -1));
        end
        n_checks++;
        if (first_hi(t_fin) != 10) begin
            n_fail++; $display("FAIL midreset_fin_cycle got %0d want 10", first_hi(t_fin));
        end
    endtask

    task automatic test_filter_only();
        logic [63:0] exp_acc;
        int k, bad;
        pulse_start(2'd0, 1'b1, 2, 4);
        trace(0, 30, 0, 0, 0);
        k = 0; bad = 0;
        for (int c = 1; c < 64; c++) if (t_hre[c]) begin
            if (t_hra[c] != k % 4) bad++;
            k++;
        end
        n_checks++;
        if (k != 8 || bad != 0) begin
            n_fail++; $display("FAIL filter_raddr_seq got %0d reads %0d bad want 8 reads 0 bad", k, bad);
        end
        n_checks++;
        if (t_owe !== bits2(12, 24)) begin
            n_fail++; $display("FAIL filter_write got %h want %h", t_owe, bits2(12, 24));
        end
        n_checks++;
        if (t_owa[12] != 0 || t_owa[24] != 1) begin
            n_fail++; $display("FAIL filter_waddr got %0d,%0d want 0,1", t_owa[12], t_owa[24]);
        end
        n_checks++;
        if (t_osel !== bits2(12, 24)) begin
            n_fail++; $display("FAIL filter_out_sel got %h want %h", t_osel, bits2(12, 24));
        end
        n_checks++;
        if (first_hi(t_fin) != 25) begin
            n_fail++; $display("FAIL filter_fin_cycle got %0d want 25", first_hi(t_fin));
        end
        n_checks++;
        if (t_clr !== bits2(3, 15)) begin
            n_fail++; $display("FAIL filter_acc_clr got %h want %h", t_clr, bits2(3, 15));
        end
        exp_acc = '0; exp_acc[4 +: 4] = 4'hF; exp_acc[16 +: 4] = 4'hF;
        n_checks++;
        if (t_acc !== exp_acc) begin
            n_fail++; $display("FAIL filter_acc_en got %h want %h", t_acc, exp_acc);
        end
        n_checks++;
        if (t_cap !== bits2(11, 23) || t_hwe !== 64'h0) begin
            n_fail++; $display("FAIL filter_result got cap %h we %h want %h 0", t_cap, t_hwe, bits2(11, 23));
        end
    endtask

    task automatic test_lms();
        pulse_start(2'd1, 1'b0, 1, 2);
        trace(1, 20, 0, 0, 0);
        n_checks++;
        if (t_hwe !== bits2(12, 13)) begin
            n_fail++; $display("FAIL lms_h_we got %h want %h", t_hwe, bits2(12, 13));
        end
        n_checks++;
        if (t_hwa[12] != 0 || t_hwa[13] != 1) begin
            n_fail++; $display("FAIL lms_h_waddr got %0d,%0d want 0,1", t_hwa[12], t_hwa[13]);
        end
        n_checks++;
        if (t_upd !== bits2(10, 11)) begin
            n_fail++; $display("FAIL lms_upd_en got %h want %h", t_upd, bits2(10, 11));
        end
        n_checks++;
        if (t_hre !== (bits2(3, 4) | bits2(9, 10))) begin
            n_fail++; $display("FAIL lms_h_re got %h want %h", t_hre, bits2(3, 4) | bits2(9, 10));
        end
        n_checks++;
        if (t_owe !== bits2(14, -1) || t_osel !== 64'h0) begin
            n_fail++; $display("FAIL lms_write got we %h sel %h want %h 0", t_owe, t_osel, bits2(14, -1));
        end
        n_checks++;
        if (first_hi(t_fin) != 15 || t_cap !== bits2(8, -1)) begin
            n_fail++; $display("FAIL lms_fin_cap got fin %0d cap %h want 15 %h", first_hi(t_fin), t_cap, bits2(8, -1));
        end
    endtask

    task automatic test_zero_counts();
        for (int z = 0; z < 2; z++) begin
            pulse_start(2'd2, 1'b1, (z == 0) ? 0 : 3, (z == 0) ? 4 : 0);
            trace(1, 6, 0, 0, 0);
            n_checks++;
            if (t_any !== 64'h0) begin
                n_fail++; $display("FAIL zero_strobes case%0d got %h want 0", z, t_any);
            end
            n_checks++;
            if (t_fin[6:1] !== 6'b111111) begin
                n_fail++; $display("FAIL zero_finished case%0d got %b want 111111", z, t_fin[6:1]);
            end
        end
    endtask

    task automatic test_en_stall();
        pulse_start(2'd2, 1'b0, 1, 2);
        trace(1, 25, 9, 5, 0);
        n_checks++;
        if (t_hre !== (bits2(3, 4) | bits2(14, 15))) begin
            n_fail++; $display("FAIL stall_h_re got %h want %h", t_hre, bits2(3, 4) | bits2(14, 15));
        end
        n_checks++;
        if (t_upd !== bits2(15, 16)) begin
            n_fail++; $display("FAIL stall_upd_en got %h want %h", t_upd, bits2(15, 16));
        end
        n_checks++;
        if (t_hwe !== bits2(17, 18) || t_hwa[17] != 0 || t_hwa[18] != 1) begin
            n_fail++; $display("FAIL stall_writeback got %h %0d,%0d want %h 0,1", t_hwe, t_hwa[17], t_hwa[18], bits2(17, 18));
        end
        n_checks++;
        if (t_owe !== bits2(19, -1) || first_hi(t_fin) != 20) begin
            n_fail++; $display("FAIL stall_end got we %h fin %0d want %h 20", t_owe, first_hi(t_fin), bits2(19, -1));
        end
    endtask

    task automatic test_back_to_back();
        pulse_start(2'd0, 1'b0, 1, 1);
        x_samples_count = 16'd5;
        trace(0, 20, 0, 0, 4);
        n_checks++;
        if ($countones(t_xre) != 1 || t_owe !== bits2(9, -1)) begin
            n_fail++; $display("FAIL ignore_start got loads %0d we %h want 1 %h", $countones(t_xre), t_owe, bits2(9, -1));
        end
        n_checks++;
        if (first_hi(t_fin) != 10) begin
            n_fail++; $display("FAIL ignore_start_fin got %0d want 10", first_hi(t_fin));
        end
        pulse_start(2'd0, 1'b0, 1, 1);
        trace(0, 12, 0, 0, 0);
        n_checks++;
        if (t_fin[1] !== 1'b0 || first_hi(t_fin) != 10) begin
            n_fail++; $display("FAIL restart_clear got fin@1 %b first %0d want 0 10", t_fin[1], first_hi(t_fin));
        end
    endtask

    initial begin
        test_reset();
        test_mid_reset();
        test_filter_only();
        test_lms();
        test_zero_counts();
        test_en_stall();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
